exception_mult: RTL and testbench

Final stage of the floating-point multiplier datapath. It sits directly downstream of the rounding stage and consumes its rounded 26-bit mantissa bus, rounded exponent, sign and rounding mode, plus the two original operands for special-value detection. It produces the packed IEEE-754 single-precision product and an 8-bit status word. It is a 2-stage pipeline with valid/ready flow control and full backpressure.

---
 rtl/round_enum_pkg.sv | 30 +++
 rtl/exception_mult_fp_classify.sv | 22 ++
 rtl/exception_mult.sv | 198 +++++++++++++++++++
 tb/tb_exception_mult.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/round_enum_pkg.sv
// Shared types for the FP multiplier back end: rounding modes, status bit
// positions and the per-operand special-value class.
package round_enum_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_values;

  localparam int ST_ZERO      = 0;
  localparam int ST_INF       = 1;
  localparam int ST_NAN       = 2;
  localparam int ST_TINY      = 3;
  localparam int ST_HUGE      = 4;
  localparam int ST_INEXACT   = 5;
  localparam int ST_DENORM_IN = 6;
  localparam int ST_INVALID   = 7;

  typedef struct packed {
    logic isnan;
    logic isinf;
    logic iszero;
    logic isdenorm;
  } fp_class_t;

endpackage

// File: rtl/exception_mult_fp_classify.sv
// Combinational special-value classification of one single-precision operand
// (sign bit excluded). Denormals report as zero and are also flagged.
module fp_classify
  import round_enum_pkg::*;
(
  input  logic [30:0] op,
  output fp_class_t   cls
);

  logic [7:0]  exp_f;
  logic [22:0] man_f;

  always_comb begin
    exp_f        = op[30:23];
    man_f        = op[22:0];
    cls.isnan    = (exp_f == 8'hFF) && (man_f != 23'h0);
    cls.isinf    = (exp_f == 8'hFF) && (man_f == 23'h0);
    cls.iszero   = (exp_f == 8'h00);
    cls.isdenorm = (exp_f == 8'h00) && (man_f != 23'h0);
  end

endmodule

// File: rtl/exception_mult.sv
// Final multiplier stage: classify (stage 1) then pack result + status (stage 2).
// Optional sticky status accumulator enabled by defining STICKY_FLAGS_EN.
module exception_mult
  import round_enum_pkg::*;
#(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic [25:0]       rounding_result,
  input  logic [9:0]        round_exponent,
  input  logic              sign,
  input  round_values       round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       z,
  output logic [7:0]        status,
  input  logic              clr_flags,
  output logic [7:0]        flags_acc
);

  localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

  // Handshake: a beat moves on a rising edge when valid & ready are both high.
  // A stage loads whenever it is empty or its content leaves the same edge, so
  // ready ripples back combinationally and a full pipe streams 1 beat/cycle.
  logic s2_advance;

  fp_class_t   cls_a, cls_b;
  logic        s1_valid_q, s1_valid_d;
  fp_class_t   cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic        e_hi_q, e_hi_d, e_lo_q, e_lo_d;
  logic        exact_q, exact_d, sign_q, sign_d;
  logic [22:0] man_q, man_d;
  logic [7:0]  exp_q, exp_d;
  round_values round_q, round_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] z_q, z_d, z_n;
  logic [7:0]  status_q, status_d, st_n;

  logic        unused_bits;
  assign unused_bits = ^{a[31], b[31], rounding_result[24:23]};

  fp_classify u_cls_a (.op(a[30:0]), .cls(cls_a));
  fp_classify u_cls_b (.op(b[30:0]), .cls(cls_b));

  assign s2_advance = ~out_valid_q | out_ready;
  assign in_ready   = ~s1_valid_q | s2_advance;
  assign out_valid  = out_valid_q;
  assign z          = z_q;
  assign status     = status_q;

  // Stage 1: capture operands classes and the overflow/underflow decision.
  always_comb begin
    s1_valid_d = s1_valid_q;
    cls_a_d    = cls_a_q;
    cls_b_d    = cls_b_q;
    e_hi_d     = e_hi_q;
    e_lo_d     = e_lo_q;
    exact_d    = exact_q;
    man_d      = man_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    round_d    = round_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        cls_a_d = cls_a;
        cls_b_d = cls_b;
        e_hi_d  = $signed(round_exponent) >= EXP_MAX;
        e_lo_d  = $signed(round_exponent) <= 10'sd0;
        exact_d = rounding_result[25];
        man_d   = rounding_result[22:0];
        exp_d   = round_exponent[7:0];
        sign_d  = sign;
        round_d = round;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      cls_a_q    <= '0;
      cls_b_q    <= '0;
      e_hi_q     <= 1'b0;
      e_lo_q     <= 1'b0;
      exact_q    <= 1'b0;
      man_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      round_q    <= IEEE_near;
    end else begin
      s1_valid_q <= s1_valid_d;
      cls_a_q    <= cls_a_d;
      cls_b_q    <= cls_b_d;
      e_hi_q     <= e_hi_d;
      e_lo_q     <= e_lo_d;
      exact_q    <= exact_d;
      man_q      <= man_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      round_q    <= round_d;
    end
  end

  // Stage 2 pack: first matching rule wins, NaN/invalid highest.
  always_comb begin
    z_n               = {sign_q, exp_q, man_q};
    st_n              = '0;
    st_n[ST_DENORM_IN] = cls_a_q.isdenorm | cls_b_q.isdenorm;
    if (cls_a_q.isnan | cls_b_q.isnan |
        (cls_a_q.isinf & cls_b_q.iszero) | (cls_a_q.iszero & cls_b_q.isinf)) begin
      z_n              = QNAN;
      st_n[ST_NAN]     = 1'b1;
      st_n[ST_INVALID] = (cls_a_q.isinf & cls_b_q.iszero) |
                         (cls_a_q.iszero & cls_b_q.isinf);
    end else if (cls_a_q.isinf | cls_b_q.isinf) begin
      z_n          = {sign_q, 8'hFF, 23'h0};
      st_n[ST_INF] = 1'b1;
    end else if (cls_a_q.iszero | cls_b_q.iszero) begin
      z_n           = {sign_q, 31'h0};
      st_n[ST_ZERO] = 1'b1;
    end else if (e_hi_q) begin
      st_n[ST_HUGE]    = 1'b1;
      st_n[ST_INEXACT] = 1'b1;
      case (round_q)
        IEEE_zero: z_n = {sign_q, 8'hFE, 23'h7FFFFF};
        IEEE_pinf: z_n = sign_q ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'h0};
        IEEE_ninf: z_n = sign_q ? {1'b1, 8'hFF, 23'h0} : {1'b0, 8'hFE, 23'h7FFFFF};
        default:   z_n = {sign_q, 8'hFF, 23'h0};
      endcase
    end else if (e_lo_q) begin
      z_n              = {sign_q, 31'h0};
      st_n[ST_TINY]    = 1'b1;
      st_n[ST_ZERO]    = 1'b1;
      st_n[ST_INEXACT] = 1'b1;
    end else begin
      st_n[ST_INEXACT] = ~exact_q;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    z_d         = z_q;
    status_d    = status_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_d      = z_n;
        status_d = st_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      status_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      status_q    <= status_d;
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [7:0] flags_acc_q, flags_acc_d;

  // A clear in the same cycle as a handshake discards that beat's flags.
  always_comb begin
    flags_acc_d = flags_acc_q;
    if (clr_flags)
      flags_acc_d = '0;
    else if (out_valid_q & out_ready)
      flags_acc_d = flags_acc_q | status_q;
  end

  always_ff @(posedge clk) begin
    if (rst) flags_acc_q <= '0;
    else     flags_acc_q <= flags_acc_d;
  end

  assign flags_acc = flags_acc_q;
`else
  logic unused_clr;
  assign unused_clr = clr_flags;
  assign flags_acc  = '0;
`endif

endmodule

// File: tb/tb_exception_mult.sv
// Directed bench for exception_mult: special values, overflow modes, underflow,
// backpressure ordering, mid-flight reset and the sticky accumulator.
module tb_exception_mult;
  import round_enum_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, sign, clr_flags;
  logic [31:0] a, b, z;
  logic [25:0] rr;
  logic [9:0]  re;
  round_values round;
  logic [7:0]  status, flags_acc;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  exception_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rounding_result(rr), .round_exponent(re), .sign(sign),
    .round(round), .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .status(status), .clr_flags(clr_flags), .flags_acc(flags_acc)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ONE = 32'h3F80_0000;

  task automatic set_in(input logic [31:0] ta, input logic [31:0] tb,
                        input logic [25:0] trr, input logic [9:0] tre,
                        input logic ts, input round_values trnd);
    a = ta; b = tb; rr = trr; re = tre; sign = ts; round = trnd;
  endtask

  // Send the currently applied inputs as one beat and return its result.
  task automatic do_beat(output logic [31:0] zo, output logic [7:0] so, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) to = 1'b1;
    zo = z; so = status;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    set_in(32'h0, 32'h0, 26'h0, 10'h0, 1'b0, IEEE_near);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (z !== 32'h0) begin bad++; $display("FAIL reset_z got=%h exp=00000000", z); end
    total++; if (status !== 8'h0) begin bad++; $display("FAIL reset_status got=%h exp=00", status); end
    total++; if (flags_acc !== 8'h0) begin bad++; $display("FAIL reset_flags_acc got=%h exp=00", flags_acc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_normal;
    logic [31:0] zo; logic [7:0] so; bit to;
    logic [31:0] ta[4], tz[4]; logic [25:0] trr[4]; logic [9:0] tre[4];
    logic ts[4]; logic [7:0] tst[4];
    ta  = '{32'h4000_0000, ONE,          ONE,          ONE};
    trr = '{{2'b10, 24'hC00000}, {2'b00, 24'hA00000}, {2'b10, 24'hFFFFFF}, {2'b10, 24'h800000}};
    tre = '{10'd129,       10'd127,      10'd254,      10'd1};
    ts  = '{1'b0,          1'b1,         1'b0,         1'b1};
    tz  = '{32'h40C0_0000, 32'hBFA0_0000, 32'h7F7F_FFFF, 32'h8080_0000};
    tst = '{8'h00,         8'h20,        8'h00,        8'h00};
    for (int i = 0; i < 4; i++) begin
      set_in(ta[i], (i == 0) ? 32'h4040_0000 : ONE, trr[i], tre[i], ts[i], IEEE_near);
      do_beat(zo, so, to);
      total++;
      if (to || zo !== tz[i] || so !== tst[i]) begin
        bad++;
        $display("FAIL normal_%0d got z=%h st=%h timeout=%0d exp z=%h st=%h", i, zo, so, to, tz[i], tst[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] zo; logic [7:0] so; bit to;
    round_values tm[6]; logic ts[6]; logic [31:0] tz[6];
    tm = '{IEEE_zero,     IEEE_near,     IEEE_pinf,     IEEE_ninf,     IEEE_ninf,     away_zero};
    ts = '{1'b0,          1'b0,          1'b1,          1'b1,          1'b0,          1'b1};
    tz = '{32'h7F7F_FFFF, 32'h7F80_0000, 32'hFF7F_FFFF, 32'hFF80_0000, 32'h7F7F_FFFF, 32'hFF80_0000};
    for (int i = 0; i < 6; i++) begin
      set_in(ONE, ONE, {2'b10, 24'h800000}, (i == 5) ? 10'd300 : 10'd255, ts[i], tm[i]);
      do_beat(zo, so, to);
      total++;
      if (to || zo !== tz[i] || so !== 8'h30) begin
        bad++;
        $display("FAIL overflow_%0d got z=%h st=%h timeout=%0d exp z=%h st=30", i, zo, so, to, tz[i]);
      end
    end
  endtask

  task automatic test_invalid;
    logic [31:0] zo; logic [7:0] so; bit to;
    logic [31:0] ta[4], tb[4], tz[4]; logic [7:0] tst[4];
    ta  = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FA0_0001, 32'h0000_0000};
    tb  = '{32'h0000_0000, ONE,           32'h7F80_0000, 32'hFF80_0000};
    tz  = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
    tst = '{8'h84,         8'h02,         8'h04,         8'h84};
    for (int i = 0; i < 4; i++) begin
      set_in(ta[i], tb[i], {2'b10, 24'h800000}, 10'd127, 1'b0, IEEE_near);
      do_beat(zo, so, to);
      total++;
      if (to || zo !== tz[i] || so !== tst[i]) begin
        bad++;
        $display("FAIL invalid_%0d got z=%h st=%h timeout=%0d exp z=%h st=%h", i, zo, so, to, tz[i], tst[i]);
      end
    end
  endtask

  task automatic test_underflow;
    logic [31:0] zo; logic [7:0] so; bit to;
    set_in(ONE, ONE, {2'b10, 24'h800000}, 10'h3FE, 1'b1, IEEE_near);
    do_beat(zo, so, to);
    total++; if (to || zo !== 32'h8000_0000 || so !== 8'h29) begin
      bad++; $display("FAIL underflow_neg got z=%h st=%h timeout=%0d exp z=80000000 st=29", zo, so, to);
    end
    set_in(ONE, ONE, {2'b10, 24'h800000}, 10'd0, 1'b0, IEEE_near);
    do_beat(zo, so, to);
    total++; if (to || zo !== 32'h0 || so !== 8'h29) begin
      bad++; $display("FAIL underflow_zero_exp got z=%h st=%h timeout=%0d exp z=00000000 st=29", zo, so, to);
    end
    set_in(32'h0000_0001, ONE, {2'b10, 24'h800000}, 10'd127, 1'b1, IEEE_near);
    do_beat(zo, so, to);
    total++; if (to || zo !== 32'h8000_0000 || so !== 8'h41) begin
      bad++; $display("FAIL denorm_flush got z=%h st=%h timeout=%0d exp z=80000000 st=41", zo, so, to);
    end
  endtask

  task automatic test_back_to_back;
    logic [25:0] brr[3]; logic [9:0] bre[3]; logic [31:0] held;
    int idx, acc;
    bit holding;
    brr = '{{2'b10, 24'hC00000}, {2'b10, 24'h800000}, {2'b00, 24'hA00000}};
    bre = '{10'd129, 10'd130, 10'd127};
    exp_q.push_back(32'h40C0_0000);
    exp_q.push_back(32'h4100_0000);
    exp_q.push_back(32'h3FA0_0000);
    idx = 0; acc = 0; holding = 1'b0; held = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 30 && (idx < 3 || exp_q.size() > 0); cyc++) begin
      out_ready = (cyc >= 4);
      if (idx < 3) begin
        set_in(ONE, ONE, brr[idx], bre[idx], 1'b0, IEEE_near);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b0 || acc != 2) begin
          bad++; $display("FAIL bp_ready_drop got in_ready=%b accepts=%0d exp in_ready=0 accepts=2", in_ready, acc);
        end
      end
      if (cyc == 3) begin
        total++; if (out_valid !== 1'b1 || z !== held) begin
          bad++; $display("FAIL bp_stall_hold got valid=%b z=%h exp valid=1 z=%h", out_valid, z, held);
        end
      end
      if (out_valid && !out_ready && !holding) begin held = z; holding = 1'b1; end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra got z=%h exp none", z);
        end else begin
          if (z !== exp_q[0]) begin bad++; $display("FAIL bp_order got z=%h exp z=%h", z, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin idx++; acc++; end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (exp_q.size() != 0 || idx != 3) begin
      bad++; $display("FAIL bp_drained got left=%0d sent=%0d exp left=0 sent=3", exp_q.size(), idx);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight;
    bit seen;
    set_in(ONE, ONE, {2'b10, 24'h800000}, 10'd127, 1'b0, IEEE_near);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_preload got valid=%b exp 1", out_valid); end
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_stale_result got out_valid seen=%b exp 0", seen); end
  endtask

  task automatic test_sticky;
    logic [31:0] zo; logic [7:0] so; bit to;
    logic [7:0] exp_acc;
`ifdef STICKY_FLAGS_EN
    exp_acc = 8'hB4;
`else
    exp_acc = 8'h00;
`endif
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    total++; if (flags_acc !== 8'h00) begin bad++; $display("FAIL sticky_clear0 got=%h exp=00", flags_acc); end
    set_in(ONE, ONE, {2'b10, 24'h800000}, 10'd255, 1'b0, IEEE_zero);
    do_beat(zo, so, to);
    set_in(32'h7F80_0000, 32'h0, {2'b10, 24'h800000}, 10'd127, 1'b0, IEEE_near);
    do_beat(zo, so, to);
    repeat (2) @(negedge clk);
    total++; if (to || flags_acc !== exp_acc) begin
      bad++; $display("FAIL sticky_accum got=%h timeout=%0d exp=%h", flags_acc, to, exp_acc);
    end
    clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    total++; if (flags_acc !== 8'h00) begin bad++; $display("FAIL sticky_clear got=%h exp=00", flags_acc); end
    // clear coinciding with a handshake must drop that beat's flags
    do_beat(zo, so, to);
    clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    total++; if (to || flags_acc !== 8'h00) begin
      bad++; $display("FAIL sticky_clear_wins got=%h timeout=%0d exp=00", flags_acc, to);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_invalid();
    test_underflow();
    test_back_to_back();
    test_reset_midflight();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
